// File: rtl/branch_pred_unit_pkg.sv
// Shared types and helpers for the branch prediction unit.
// The optional statistics counters are enabled with the BPU_STATS_EN macro.
package branch_pred_unit_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } bpu_state_e;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/bpu_ctr_sat.sv
// Saturating up/down direction counter step: increments toward all-ones when
// inc=1, decrements toward zero otherwise.
module bpu_ctr_sat #(
    parameter int CTR_WIDTH = 2
) (
    input  logic [CTR_WIDTH-1:0] ctr,
    input  logic                 inc,
    output logic [CTR_WIDTH-1:0] ctr_next
);

    localparam logic [CTR_WIDTH-1:0] CTR_MAX = '1;

    always_comb begin
        ctr_next = ctr;
        if (inc) begin
            if (ctr != CTR_MAX) ctr_next = ctr + CTR_WIDTH'(1);
        end else begin
            if (ctr != '0) ctr_next = ctr - CTR_WIDTH'(1);
        end
    end

endmodule

// File: rtl/branch_pred_unit.sv
// Tagged BTB with saturating direction counters, self-clearing after reset.
// Define BPU_STATS_EN to add saturating lookup/hit/update/mispredict counters.
module branch_pred_unit
    import branch_pred_unit_pkg::*;
#(
    parameter int PC_WIDTH  = 30,
    parameter int IDX_WIDTH = 10,
    parameter int TAG_WIDTH = 8,
    parameter int CTR_WIDTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PC_WIDTH-1:0] lk_pc,
    output logic                pred_hit,
    output logic                pred_taken,
    output logic [PC_WIDTH-1:0] pred_target,
    input  logic                upd_en,
    input  logic [PC_WIDTH-1:0] upd_pc,
    input  logic                upd_taken,
    input  logic                upd_uncond,
    input  logic [PC_WIDTH-1:0] upd_target,
    output logic                ready
`ifdef BPU_STATS_EN
    ,
    output logic [31:0]         stat_lookups,
    output logic [31:0]         stat_hits,
    output logic [31:0]         stat_updates,
    output logic [31:0]         stat_mispred
`endif
);

    localparam int DEPTH = 1 << IDX_WIDTH;
    localparam logic [CTR_WIDTH-1:0] CTR_WEAK = CTR_WIDTH'(1) << (CTR_WIDTH - 1);

    typedef struct packed {
        logic                 valid;
        logic [TAG_WIDTH-1:0] tag;
        logic                 uncond;
        logic [CTR_WIDTH-1:0] ctr;
        logic [PC_WIDTH-1:0]  target;
    } entry_t;

    entry_t mem [DEPTH];

    bpu_state_e           state, state_nxt;
    logic [IDX_WIDTH-1:0] sweep_idx, sweep_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_INIT;
            sweep_idx <= '0;
        end else begin
            state     <= state_nxt;
            sweep_idx <= sweep_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sweep_nxt = sweep_idx;
        case (state)
            ST_INIT: begin
                sweep_nxt = sweep_idx + IDX_WIDTH'(1);
                if (sweep_idx == '1) state_nxt = ST_RUN;
            end
            default: state_nxt = state;
        endcase
    end

    assign ready = (state == ST_RUN);

    // Update read-modify-write; the read sees every earlier write, so
    // back-to-back updates to one index chain naturally.
    logic [IDX_WIDTH-1:0] upd_idx;
    logic [TAG_WIDTH-1:0] upd_tag;
    entry_t               upd_cur;
    logic                 upd_hit;
    logic [CTR_WIDTH-1:0] ctr_next;

    assign upd_idx = upd_pc[IDX_WIDTH-1:0];
    assign upd_tag = upd_pc[IDX_WIDTH +: TAG_WIDTH];
    assign upd_cur = mem[upd_idx];
    assign upd_hit = upd_cur.valid && (upd_cur.tag == upd_tag);

    bpu_ctr_sat #(.CTR_WIDTH(CTR_WIDTH)) u_ctr_sat (
        .ctr      (upd_cur.ctr),
        .inc      (upd_taken),
        .ctr_next (ctr_next)
    );

    logic                 wr_en;
    logic [IDX_WIDTH-1:0] wr_idx;
    entry_t               wr_entry;

    always_comb begin
        wr_en    = 1'b0;
        wr_idx   = upd_idx;
        wr_entry = upd_cur;
        if (state == ST_INIT) begin
            wr_en    = 1'b1;
            wr_idx   = sweep_idx;
            wr_entry = '0;
        end else if (upd_en) begin
            if (upd_hit) begin
                wr_en        = 1'b1;
                wr_entry.ctr = ctr_next;
                if (upd_taken) begin
                    wr_entry.target = upd_target;
                    wr_entry.uncond = upd_uncond;
                end
            end else if (upd_taken) begin
                wr_en    = 1'b1;
                wr_entry = '{valid: 1'b1, tag: upd_tag, uncond: upd_uncond,
                             ctr: CTR_WEAK, target: upd_target};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= wr_entry;
    end

    // Lookup: a same-cycle write to the looked-up index is forwarded.
    logic [IDX_WIDTH-1:0] lk_idx;
    entry_t               lk_cur;
    logic                 lk_hit;
    logic                 lk_taken;
    logic [PC_WIDTH-1:0]  lk_target;

    assign lk_idx    = lk_pc[IDX_WIDTH-1:0];
    assign lk_cur    = (wr_en && (wr_idx == lk_idx)) ? wr_entry : mem[lk_idx];
    assign lk_hit    = (state == ST_RUN) && lk_cur.valid &&
                       (lk_cur.tag == lk_pc[IDX_WIDTH +: TAG_WIDTH]);
    assign lk_taken  = lk_hit && (lk_cur.uncond || lk_cur.ctr[CTR_WIDTH-1]);
    assign lk_target = lk_taken ? lk_cur.target : lk_pc + PC_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            pred_hit    <= 1'b0;
            pred_taken  <= 1'b0;
            pred_target <= '0;
        end else begin
            pred_hit    <= lk_hit;
            pred_taken  <= lk_taken;
            pred_target <= lk_target;
        end
    end

    if (PC_WIDTH > IDX_WIDTH + TAG_WIDTH) begin : g_pc_hi
        logic unused_upd_hi;
        assign unused_upd_hi = ^upd_pc[PC_WIDTH-1:IDX_WIDTH+TAG_WIDTH];
    end

`ifdef BPU_STATS_EN
    logic pre_taken;
    logic upd_mispred;

    assign pre_taken   = upd_hit && (upd_cur.uncond || upd_cur.ctr[CTR_WIDTH-1]);
    assign upd_mispred = (pre_taken != upd_taken) ||
                         (upd_taken && (upd_cur.target != upd_target));

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_lookups <= '0;
            stat_hits    <= '0;
            stat_updates <= '0;
            stat_mispred <= '0;
        end else if (state == ST_RUN) begin
            stat_lookups <= sat_inc32(stat_lookups);
            if (lk_hit) stat_hits <= sat_inc32(stat_hits);
            if (upd_en) stat_updates <= sat_inc32(stat_updates);
            if (upd_en && upd_mispred) stat_mispred <= sat_inc32(stat_mispred);
        end
    end
`endif

endmodule
